// File: rtl/fpa_pkg.sv
// Shared definitions for the fixed-point add/sub scheduler.
// The data format is two's-complement Q16.15 in a 32-bit word.
package fpa_pkg;

   localparam int FX_W   = 32;
   localparam int FRAC_W = 15;

   typedef logic signed [FX_W-1:0] fx_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam fx_t FX_MAX = 32'h7FFFFFFF;
   localparam fx_t FX_MIN = 32'h80000000;

endpackage

// File: rtl/fpa_addsub_core.sv
// Combinational Q16.15 add/subtract.
// The sum is formed one bit wider than the operands so that the carry-out
// and the result sign can be compared to detect overflow. On overflow the
// result is either clamped to the representable extreme or left to wrap.
module fpa_addsub_core
   import fpa_pkg::*;
#(
   parameter bit SATURATE = 1'b1
) (
   input  logic [FX_W-1:0] a,
   input  logic [FX_W-1:0] b,
   input  logic            op,
   output logic [FX_W-1:0] y,
   output logic            ovf
);

   logic [FX_W:0] sum_ext;

   // Sign-extended add/sub, overflow detection and optional clamp.
   always_comb begin
      sum_ext = '0;
      if (op_e'(op) == OP_SUB) begin
         sum_ext = {a[FX_W-1], a} - {b[FX_W-1], b};
      end else begin
         sum_ext = {a[FX_W-1], a} + {b[FX_W-1], b};
      end

      ovf = sum_ext[FX_W] ^ sum_ext[FX_W-1];
      y   = sum_ext[FX_W-1:0];

      if (SATURATE && ovf) begin
         y = sum_ext[FX_W] ? FX_MIN : FX_MAX;
      end
   end

endmodule

// File: rtl/fpa_addsub_sched.sv
// Round-robin scheduler sharing one add/sub datapath between N_REQ requesters.
// Each requester may have one operation in flight. An accepted operation is
// registered into stage 1, computed in stage 2 and written into a dedicated
// per-requester result buffer, so the pipeline never has to stall. The pend
// bit of a requester stays set from accept until its result is consumed.
module fpa_addsub_sched
   import fpa_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter bit SATURATE = 1'b1,
   localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ-1:0]        req_op,
   input  logic [N_REQ*FX_W-1:0]   req_a,
   input  logic [N_REQ*FX_W-1:0]   req_b,
   output logic [N_REQ-1:0]        resp_valid,
   input  logic [N_REQ-1:0]        resp_ready,
   output logic [N_REQ*FX_W-1:0]   resp_y,
   output logic [N_REQ-1:0]        resp_ovf,
   output logic [IDX_W-1:0]        grant_id
);

   logic [N_REQ-1:0][FX_W-1:0] a_vec;
   logic [N_REQ-1:0][FX_W-1:0] b_vec;

   logic [N_REQ-1:0]           pend;
   logic [N_REQ-1:0]           eligible;
   logic [IDX_W-1:0]           rr_ptr;
   logic [IDX_W-1:0]           grant_q;
   logic [IDX_W-1:0]           cand;
   logic [IDX_W-1:0]           win_idx;
   logic                       win_found;
   logic                       accept;

   logic                       s1_v;
   logic                       s1_op;
   logic [FX_W-1:0]            s1_a;
   logic [FX_W-1:0]            s1_b;
   logic [IDX_W-1:0]           s1_idx;

   logic [FX_W-1:0]            core_y;
   logic                       core_ovf;

   logic [N_REQ-1:0]           rsp_v;
   logic [N_REQ-1:0][FX_W-1:0] ybuf;
   logic [N_REQ-1:0]           obuf;

   assign a_vec      = req_a;
   assign b_vec      = req_b;
   assign resp_y     = ybuf;
   assign resp_ovf   = obuf;
   assign resp_valid = rsp_v;
   assign grant_id   = grant_q;
   assign accept     = |(req_valid & req_ready);

   // Round-robin search starting just after the last winner; ready is held low during reset.
   always_comb begin
      eligible  = req_valid & ~pend;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      req_ready = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      if (rst_n && win_found) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   fpa_addsub_core #(
      .SATURATE (SATURATE)
   ) u_core (
      .a   (s1_a),
      .b   (s1_b),
      .op  (s1_op),
      .y   (core_y),
      .ovf (core_ovf)
   );

   // Accept into stage 1, write stage-2 results to buffers, retire consumed results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend    <= '0;
         rsp_v   <= '0;
         ybuf    <= '0;
         obuf    <= '0;
         rr_ptr  <= IDX_W'(N_REQ - 1);
         grant_q <= '0;
         s1_v    <= 1'b0;
         s1_op   <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_idx  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (rsp_v[i] && resp_ready[i]) begin
               rsp_v[i] <= 1'b0;
               pend[i]  <= 1'b0;
            end
         end

         s1_v <= accept;
         if (accept) begin
            pend[win_idx] <= 1'b1;
            rr_ptr        <= win_idx;
            grant_q       <= win_idx;
            s1_a          <= a_vec[win_idx];
            s1_b          <= b_vec[win_idx];
            s1_op         <= req_op[win_idx];
            s1_idx        <= win_idx;
         end

         if (s1_v) begin
            ybuf[s1_idx]  <= core_y;
            obuf[s1_idx]  <= core_ovf;
            rsp_v[s1_idx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fpa_addsub_sched.sv
// Directed testbench for fpa_addsub_sched. Two instances share stimulus:
// one clamps on overflow, the other wraps.
module tb_fpa_addsub_sched;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_op;
   logic [N*32-1:0]  req_a;
   logic [N*32-1:0]  req_b;
   logic [N-1:0]     resp_ready;

   logic [N-1:0]     req_ready,  req_ready_w;
   logic [N-1:0]     resp_valid, resp_valid_w;
   logic [N*32-1:0]  resp_y,     resp_y_w;
   logic [N-1:0]     resp_ovf,   resp_ovf_w;
   logic [1:0]       grant_id,   grant_id_w;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int check_cnt = 0;

   int seq3 [3] = '{0, 2, 3};
   int exp_idx;

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   fpa_addsub_sched #(.N_REQ(N), .SATURATE(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_y     (resp_y),
      .resp_ovf   (resp_ovf),
      .grant_id   (grant_id)
   );

   fpa_addsub_sched #(.N_REQ(N), .SATURATE(1'b0)) dut_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready_w),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid_w),
      .resp_ready (resp_ready),
      .resp_y     (resp_y_w),
      .resp_ovf   (resp_ovf_w),
      .grant_id   (grant_id_w)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   // Issue one operation on a single requester, follow it to its result and consume it.
   task automatic applyStimulus(input string tag, input int idx, input logic op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] y_sat, input logic [31:0] y_wrap,
                                input logic ovf);
      req_valid            = '0;
      req_valid[idx]       = 1'b1;
      req_op[idx]          = op;
      req_a[idx*32 +: 32]  = a;
      req_b[idx*32 +: 32]  = b;
      sample();
      checkOutput({tag, " ready"},   32'(req_ready),   32'(1) << idx);
      checkOutput({tag, " ready_w"}, 32'(req_ready_w), 32'(1) << idx);
      cycle();
      req_valid = '0;
      sample();
      checkOutput({tag, " valid T+1"}, 32'(resp_valid[idx]), 32'(0));
      checkOutput({tag, " grant_id"},  32'(grant_id),        32'(idx));
      cycle();
      sample();
      checkOutput({tag, " valid T+2"}, 32'(resp_valid),          32'(1) << idx);
      checkOutput({tag, " y sat"},     resp_y[idx*32 +: 32],     y_sat);
      checkOutput({tag, " ovf sat"},   32'(resp_ovf[idx]),       32'(ovf));
      checkOutput({tag, " y wrap"},    resp_y_w[idx*32 +: 32],   y_wrap);
      checkOutput({tag, " ovf wrap"},  32'(resp_ovf_w[idx]),     32'(ovf));
      cycle();
      sample();
      checkOutput({tag, " held valid"}, 32'(resp_valid[idx]),    32'(1));
      checkOutput({tag, " held y"},     resp_y[idx*32 +: 32],    y_sat);
      checkOutput({tag, " no regrant"}, 32'(req_ready),          32'(0));
      resp_ready[idx] = 1'b1;
      cycle();
      resp_ready = '0;
      sample();
      checkOutput({tag, " consumed"}, 32'(resp_valid[idx]), 32'(0));
      cycle();
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = '1;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = '0;

      // Reset state with all requesters asking.
      cycle();
      cycle();
      sample();
      checkOutput("reset ready",    32'(req_ready),  32'(0));
      checkOutput("reset resp_v",   32'(resp_valid), 32'(0));
      checkOutput("reset resp_ovf", 32'(resp_ovf),   32'(0));
      checkOutput("reset y0",       resp_y[31:0],    32'(0));
      checkOutput("reset grant",    32'(grant_id),   32'(0));
      cycle();
      req_valid = '0;
      rst_n     = 1'b1;
      cycle();

      // Basic arithmetic and overflow boundaries.
      applyStimulus("add basic",  0, 1'b0, 32'h0000C000, 32'h00012000, 32'h0001E000, 32'h0001E000, 1'b0);
      applyStimulus("add posovf", 1, 1'b0, 32'h7FFF8000, 32'h00008000, 32'h7FFFFFFF, 32'h80000000, 1'b1);
      applyStimulus("sub posovf", 2, 1'b1, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1);
      applyStimulus("add negovf", 3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b1);
      applyStimulus("sub signed", 2, 1'b1, 32'hFFFF8000, 32'h00010000, 32'hFFFE8000, 32'hFFFE8000, 1'b0);
      applyStimulus("add maxedge",1, 1'b0, 32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);

      // Reset the cycle after accepting requester 2.
      doReset();
      req_valid         = 4'b0100;
      req_op[2]         = 1'b0;
      req_a[64 +: 32]   = 32'h00008000;
      req_b[64 +: 32]   = 32'h00008000;
      sample();
      checkOutput("rst mid ready", 32'(req_ready), 32'h4);
      cycle();
      rst_n     = 1'b0;
      req_valid = '1;
      sample();
      checkOutput("rst mid hold ready", 32'(req_ready), 32'(0));
      cycle();
      sample();
      checkOutput("rst mid ready2", 32'(req_ready),  32'(0));
      checkOutput("rst mid resp_v", 32'(resp_valid), 32'(0));
      cycle();
      rst_n     = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         sample();
         checkOutput("rst mid no resp", 32'(resp_valid), 32'(0));
         cycle();
      end
      req_valid = '1;
      sample();
      checkOutput("rst mid first grant", 32'(req_ready), 32'h1);
      cycle();

      // Round robin with all requesters continuously active and consuming.
      doReset();
      for (int i = 0; i < N; i++) begin
         req_op[i]          = 1'b0;
         req_a[i*32 +: 32]  = 32'(i) << 15;
         req_b[i*32 +: 32]  = 32'h00008000;
      end
      resp_ready = '1;
      req_valid  = '1;
      for (int c = 0; c < 10; c++) begin
         sample();
         checkOutput("rr ready", 32'(req_ready), 32'(1) << (c % 4));
         if (c >= 1) checkOutput("rr grant", 32'(grant_id), 32'((c - 1) % 4));
         if (c >= 2) begin
            checkOutput("rr resp_v", 32'(resp_valid), 32'(1) << ((c - 2) % 4));
            checkOutput("rr y", resp_y[((c - 2) % 4)*32 +: 32], 32'(((c - 2) % 4) + 1) << 15);
         end
         cycle();
      end

      // Backpressure on requester 1 while the others keep being served.
      doReset();
      req_op[1]        = 1'b1;
      req_a[32 +: 32]  = 32'h00010000;
      req_b[32 +: 32]  = 32'h0000C000;
      resp_ready = 4'b1101;
      req_valid  = '1;
      for (int c = 0; c < 15; c++) begin
         if (c == 13) resp_ready[1] = 1'b1;
         if (c < 4)       exp_idx = c;
         else if (c < 14) exp_idx = seq3[(c - 4) % 3];
         else             exp_idx = 1;
         sample();
         checkOutput("bp ready", 32'(req_ready), 32'(1) << exp_idx);
         if (c >= 3 && c <= 13) begin
            checkOutput("bp hold valid", 32'(resp_valid[1]), 32'(1));
            checkOutput("bp hold y",     resp_y[32 +: 32],   32'h00004000);
            checkOutput("bp hold ovf",   32'(resp_ovf[1]),   32'(0));
         end
         if (c == 14) checkOutput("bp released", 32'(resp_valid[1]), 32'(0));
         cycle();
      end
      req_valid  = '0;
      resp_ready = '0;
      cycle();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
